sparse_pp_sequencer: RTL and testbench



---
 rtl/sparse_pp_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_sparse_pp_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_pp_sequencer.sv
// sparse_pp_sequencer
//   Control/accumulate stage wrapped around the partial-product lookup ROM `list`.
//   Splits two packed operands into COMP_W-bit components, issues one
//   (comp1, comp2, i, j) pair per cycle in row-major order, and accumulates the
//   partial product that `list` returns one cycle after each issue.
//
//   Optional feature (macro SPARSE_SKIP_ZERO_EN):
//     defined   - only pairs with both components non-zero are issued
//     undefined - all NUM_COMP*NUM_COMP pairs are issued
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a multiply (sampled only in IDLE)
//   a_in, b_in   packed operands, component k = x[k*COMP_W +: COMP_W]
//   comp1, comp2 A/B components of the current issue (to `list`)
//   i, j         A/B component indices of the current issue (to `list`)
//   issue_valid  high in cycles carrying a real issue
//   list_data    registered `list` output, valid one cycle after issue
//   busy         high whenever not IDLE
//   done         one-cycle pulse, result is final
//   result       accumulated sum of partial products
module sparse_pp_sequencer #(
    parameter int unsigned COMP_W   = 4,
    parameter int unsigned NUM_COMP = 4,
    parameter int unsigned DATA_W   = 17,
    parameter int unsigned ACC_W    = 21
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_COMP*COMP_W-1:0]   a_in,
    input  logic [NUM_COMP*COMP_W-1:0]   b_in,
    output logic [COMP_W-1:0]            comp1,
    output logic [COMP_W-1:0]            comp2,
    output logic [2:0]                   i,
    output logic [2:0]                   j,
    output logic                         issue_valid,
    input  logic [DATA_W-1:0]            list_data,
    output logic                         busy,
    output logic                         done,
    output logic [ACC_W-1:0]             result
);

    localparam int unsigned OpW   = NUM_COMP * COMP_W;
    localparam int unsigned NPair = NUM_COMP * NUM_COMP;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    state_e             state_q;
    logic [OpW-1:0]     a_q, b_q;
    logic [NPair-1:0]   mask_q;
    logic               inflight_q;

    logic [OpW-1:0]     a_src, b_src;
    logic [NPair-1:0]   start_mask;
    logic [NPair-1:0]   pick_src;
    logic [NPair-1:0]   pick_left;
    logic               pick_found;
    logic [2:0]         pick_i, pick_j;

    assign busy = (state_q != StIdle);

    // Pair mask built from the live operands at start.
    always_comb begin
        start_mask = '0;
        for (int ii = 0; ii < int'(NUM_COMP); ii++) begin
            for (int jj = 0; jj < int'(NUM_COMP); jj++) begin
`ifdef SPARSE_SKIP_ZERO_EN
                start_mask[ii*NUM_COMP+jj] = (a_in[ii*COMP_W +: COMP_W] != '0) &&
                                             (b_in[jj*COMP_W +: COMP_W] != '0);
`else
                start_mask[ii*NUM_COMP+jj] = 1'b1;
`endif
            end
        end
    end

    // Outputs are registered, so the pair picked here is the one shown in the
    // next cycle: from the fresh mask/operands in IDLE, else from the remaining mask.
    assign pick_src = (state_q == StIdle) ? start_mask : mask_q;
    assign a_src    = (state_q == StIdle) ? a_in : a_q;
    assign b_src    = (state_q == StIdle) ? b_in : b_q;

    // Lowest set bit in row-major order (i outer, j inner).
    always_comb begin
        pick_found = 1'b0;
        pick_i     = '0;
        pick_j     = '0;
        pick_left  = pick_src;
        for (int ii = 0; ii < int'(NUM_COMP); ii++) begin
            for (int jj = 0; jj < int'(NUM_COMP); jj++) begin
                if (!pick_found && pick_src[ii*NUM_COMP+jj]) begin
                    pick_found                 = 1'b1;
                    pick_i                     = 3'(ii);
                    pick_j                     = 3'(jj);
                    pick_left[ii*NUM_COMP+jj]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            mask_q      <= '0;
            inflight_q  <= 1'b0;
            comp1       <= '0;
            comp2       <= '0;
            i           <= '0;
            j           <= '0;
            issue_valid <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            // Issue outputs and done default low; overridden below when active.
            comp1       <= '0;
            comp2       <= '0;
            i           <= '0;
            j           <= '0;
            issue_valid <= 1'b0;
            done        <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q        <= a_in;
                        b_q        <= b_in;
                        result     <= '0;
                        inflight_q <= 1'b0;
                        if (pick_found) begin
                            comp1       <= a_src[pick_i*COMP_W +: COMP_W];
                            comp2       <= b_src[pick_j*COMP_W +: COMP_W];
                            i           <= pick_i;
                            j           <= pick_j;
                            issue_valid <= 1'b1;
                            mask_q      <= pick_left;
                            state_q     <= StIssue;
                        end else begin
                            mask_q  <= '0;
                            state_q <= StDrain;
                        end
                    end
                end
                StIssue: begin
                    // Every ISSUE cycle carries an issue, so data arrives next cycle.
                    inflight_q <= 1'b1;
                    if (inflight_q) begin
                        result <= result + ACC_W'(list_data);
                    end
                    if (pick_found) begin
                        comp1       <= a_src[pick_i*COMP_W +: COMP_W];
                        comp2       <= b_src[pick_j*COMP_W +: COMP_W];
                        i           <= pick_i;
                        j           <= pick_j;
                        issue_valid <= 1'b1;
                        mask_q      <= pick_left;
                    end else begin
                        mask_q  <= '0;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (inflight_q) begin
                        result <= result + ACC_W'(list_data);
                    end
                    inflight_q <= 1'b0;
                    done       <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_pp_sequencer.sv
// Bench for sparse_pp_sequencer: a 1-cycle registered `list` model
// (data = ((comp1+comp2)&7) << (i+j)), a table of directed operand vectors
// with hand-computed results, plus hand sequences for start-while-busy and
// reset mid-operation.
module tb_sparse_pp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in, b_in;
    logic [3:0]  comp1, comp2;
    logic [2:0]  i, j;
    logic        issue_valid;
    logic [16:0] list_data = '0;
    logic        busy, done;
    logic [20:0] result;

    int n_pass  = 0;
    int n_total = 0;

    sparse_pp_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .comp1       (comp1),
        .comp2       (comp2),
        .i           (i),
        .j           (j),
        .issue_valid (issue_valid),
        .list_data   (list_data),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    // `list` model
    always @(posedge clk) begin
        list_data <= 17'(((32'(comp1) + 32'(comp2)) & 32'd7) << (32'(i) + 32'(j)));
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          n;
        int          res;
        int          fi, fj, fc1, fc2;
        int          si, sj;
    } vec_t;

    vec_t vecs[5];

    // Observations from the last run_op
    int r_n, r_dcyc, r_fi, r_fj, r_fc1, r_fc2, r_si, r_sj;
    int r_busy1, r_zero_ok, r_res, r_done_after, r_busy_after, r_res_hold;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Start an operation and observe it until done (bounded). pulse_cyc>0
    // re-pulses start with different operands in that cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int pulse_cyc);
        int cyc;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        r_n       = 0;
        r_dcyc    = 0;
        r_zero_ok = 1;
        r_busy1   = int'(busy);
        r_fi = -1; r_fj = -1; r_fc1 = -1; r_fc2 = -1; r_si = -1; r_sj = -1;
        while (r_dcyc == 0 && cyc <= 100) begin
            if (pulse_cyc == cyc) begin
                start = 1'b1;
                a_in  = 16'h0000;
                b_in  = 16'h0000;
            end else begin
                start = 1'b0;
            end
            if (issue_valid) begin
                r_n++;
                if (r_n == 1) begin
                    r_fi = int'(i); r_fj = int'(j); r_fc1 = int'(comp1); r_fc2 = int'(comp2);
                end else if (r_n == 2) begin
                    r_si = int'(i); r_sj = int'(j);
                end
            end else if ((comp1 | comp2) != 4'd0 || (i | j) != 3'd0) begin
                r_zero_ok = 0;
            end
            if (done) begin
                r_dcyc = cyc;
                r_res  = int'(result);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        @(negedge clk);
        r_done_after = int'(done);
        r_busy_after = int'(busy);
        @(negedge clk);
        r_res_hold = int'(result);
    endtask

    task automatic check_vec(input int k, input vec_t v);
        chk($sformatf("v%0d issues", k), r_n, v.n);
        chk($sformatf("v%0d done_cycle", k), r_dcyc, v.n + 2);
        chk($sformatf("v%0d result", k), r_res, v.res);
        chk($sformatf("v%0d result_hold", k), r_res_hold, v.res);
        chk($sformatf("v%0d busy_c1", k), r_busy1, 1);
        chk($sformatf("v%0d idle_outputs_zero", k), r_zero_ok, 1);
        chk($sformatf("v%0d done_after", k), r_done_after, 0);
        chk($sformatf("v%0d busy_after", k), r_busy_after, 0);
        if (v.n > 0) begin
            chk($sformatf("v%0d first_i", k), r_fi, v.fi);
            chk($sformatf("v%0d first_j", k), r_fj, v.fj);
            chk($sformatf("v%0d first_comp1", k), r_fc1, v.fc1);
            chk($sformatf("v%0d first_comp2", k), r_fc2, v.fc2);
        end
        if (v.n > 1) begin
            chk($sformatf("v%0d second_i", k), r_si, v.si);
            chk($sformatf("v%0d second_j", k), r_sj, v.sj);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " comp1"}, int'(comp1), 0);
        chk({tag, " comp2"}, int'(comp2), 0);
        chk({tag, " i"}, int'(i), 0);
        chk({tag, " j"}, int'(j), 0);
        chk({tag, " issue_valid"}, int'(issue_valid), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " result"}, int'(result), 0);
    endtask

    initial begin
`ifdef SPARSE_SKIP_ZERO_EN
        vecs[0] = '{a: 16'h0001, b: 16'h0001, n: 1,  res: 2,    fi: 0, fj: 0, fc1: 1,  fc2: 1,
                    si: 0, sj: 0};
        vecs[1] = '{a: 16'h0000, b: 16'h1234, n: 0,  res: 0,    fi: 0, fj: 0, fc1: 0,  fc2: 0,
                    si: 0, sj: 0};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, n: 16, res: 1350, fi: 0, fj: 0, fc1: 15, fc2: 15,
                    si: 0, sj: 1};
        vecs[3] = '{a: 16'h0010, b: 16'h0100, n: 1,  res: 16,   fi: 1, fj: 2, fc1: 1,  fc2: 1,
                    si: 0, sj: 0};
        vecs[4] = '{a: 16'h0101, b: 16'h0011, n: 4,  res: 30,   fi: 0, fj: 0, fc1: 1,  fc2: 1,
                    si: 0, sj: 1};
`else
        vecs[0] = '{a: 16'h0001, b: 16'h0001, n: 16, res: 30,   fi: 0, fj: 0, fc1: 1,  fc2: 1,
                    si: 0, sj: 1};
        vecs[1] = '{a: 16'h0000, b: 16'h1234, n: 16, res: 390,  fi: 0, fj: 0, fc1: 0,  fc2: 4,
                    si: 0, sj: 1};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, n: 16, res: 1350, fi: 0, fj: 0, fc1: 15, fc2: 15,
                    si: 0, sj: 1};
        vecs[3] = '{a: 16'h0010, b: 16'h0100, n: 16, res: 90,   fi: 0, fj: 0, fc1: 0,  fc2: 0,
                    si: 0, sj: 1};
        vecs[4] = '{a: 16'h0101, b: 16'h0011, n: 16, res: 120,  fi: 0, fj: 0, fc1: 1,  fc2: 1,
                    si: 0, sj: 1};
`endif

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            run_op(vecs[k].a, vecs[k].b, 0);
            check_vec(k, vecs[k]);
        end

        // start while busy: re-pulse in cycle 5 with other operands, ignored
        run_op(16'hFFFF, 16'hFFFF, 5);
        chk("busy_start issues", r_n, 16);
        chk("busy_start done_cycle", r_dcyc, 18);
        chk("busy_start result", r_res, 1350);

        // reset in the 3rd issue cycle aborts at once
        begin
            int saw_done;
            int iv3;
            @(negedge clk);
            a_in  = 16'hFFFF;
            b_in  = 16'hFFFF;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            iv3 = int'(issue_valid);
            chk("abort issue_valid_c3", iv3, 1);
            rst = 1'b1;
            #1;
            check_outputs_zero("abort");
            #1;
            rst = 1'b0;
            saw_done = 0;
            repeat (6) begin
                @(negedge clk);
                if (done || busy) saw_done = 1;
            end
            chk("abort no_done", saw_done, 0);
        end
        run_op(vecs[0].a, vecs[0].b, 0);
        check_vec(10, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
